// File: rtl/twos_pkg.sv
// Shared definitions for the two's-complement conversion unit: FSM states and
// default operand geometry.
package twos_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_OPS = 2;
    localparam int DEF_OPC_W   = 4;

endpackage

// File: rtl/twos_neg_core.sv
// Combinational negate-or-pass core: invert, add one, flag the most-negative operand.
// Define TWOS_SAT_EN to clamp the negated minimum to the maximum positive value.
module twos_neg_core
    import twos_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic signed [WIDTH-1:0] op,
    input  logic                    neg,
    output logic signed [WIDTH-1:0] res,
    output logic                    min_ovf
);

    localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic                    is_min;
    logic signed [WIDTH-1:0] negated;
    logic signed [WIDTH-1:0] neg_final;

    assign is_min  = (op == MIN_NEG);
    assign negated = ~op + ONE;

`ifdef TWOS_SAT_EN
    localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    function automatic logic signed [WIDTH-1:0] sat_neg(
        input logic signed [WIDTH-1:0] neg_val,
        input logic                    min_in
    );
        return min_in ? MAX_POS : neg_val;
    endfunction

    assign neg_final = sat_neg(negated, is_min);
`else
    // Negating the minimum wraps back onto itself.
    assign neg_final = negated;
`endif

    assign res     = neg ? neg_final : op;
    assign min_ovf = neg & is_min;

endmodule

// File: rtl/twos_complement_unit.sv
// Sequential two's-complement unit: converts packed operands one per cycle through
// a shared twos_neg_core. Define TWOS_SAT_EN for saturating negation.
module twos_complement_unit
    import twos_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_OPS = DEF_NUM_OPS,
    parameter int OPC_W   = DEF_OPC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_OPS*WIDTH+OPC_W-1:0] nr_coded,
    input  logic [NUM_OPS-1:0]         neg_mask,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_OPS*WIDTH-1:0]   ops_out,
    output logic [OPC_W-1:0]           operation,
    output logic [NUM_OPS-1:0]         ovf
);

    localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

    state_t state, state_nxt;
    logic [IDX_W-1:0] idx;

    // Working copies are indexed by operand number; mask and ovf bits follow
    // the operand packing, so operand 0 maps to the MSB of each vector.
    logic signed [WIDTH-1:0] src      [NUM_OPS];
    logic signed [WIDTH-1:0] work     [NUM_OPS];
    logic                    neg_cap  [NUM_OPS];
    logic                    ovf_work [NUM_OPS];
    logic [OPC_W-1:0]        opc_cap;

    logic signed [WIDTH-1:0] core_res;
    logic                    core_ovf;
    logic                    accept;

    assign accept = (state == IDLE) && start && !done;

    twos_neg_core #(.WIDTH(WIDTH)) u_neg_core (
        .op      (src[idx]),
        .neg     (neg_cap[idx]),
        .res     (core_res),
        .min_ovf (core_ovf)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CONV;
            CONV:    if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ops_out   <= '0;
            operation <= '0;
            ovf       <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx  <= '0;
                        busy <= 1'b1;
                    end
                end
                CONV: idx <= idx + 1'b1;
                DONE: begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    operation <= opc_cap;
                    for (int i = 0; i < NUM_OPS; i++) begin
                        ops_out[(NUM_OPS-1-i)*WIDTH +: WIDTH] <= work[i];
                        ovf[NUM_OPS-1-i]                      <= ovf_work[i];
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture and per-operand working storage; no reset needed on the data path.
    always_ff @(posedge clk) begin
        if (accept) begin
            opc_cap <= nr_coded[OPC_W-1:0];
            for (int i = 0; i < NUM_OPS; i++) begin
                src[i]     <= nr_coded[OPC_W + (NUM_OPS-1-i)*WIDTH +: WIDTH];
                neg_cap[i] <= neg_mask[NUM_OPS-1-i];
            end
        end
        if (state == CONV) begin
            work[idx]     <= core_res;
            ovf_work[idx] <= core_ovf;
        end
    end

endmodule

// File: tb/tb_twos_complement_unit.sv
// Self-checking bench for twos_complement_unit (WIDTH=4, NUM_OPS=2, OPC_W=4):
// vector table, randomized runs against an arithmetic model, and control corner cases.
module tb_twos_complement_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] nr_coded;
    logic [1:0]  neg_mask;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  ops_out;
    logic [3:0]  operation;
    logic [1:0]  ovf;

    int total = 0;
    int bad   = 0;

    logic [7:0] prev_ops;
    logic [1:0] prev_ovf;
    logic [3:0] prev_opc;

    typedef struct {
        logic [11:0] nr;
        logic [1:0]  m;
        logic [7:0]  e_ops;
        logic [1:0]  e_ovf;
    } vec_t;

    vec_t tbl [8];

    twos_complement_unit #(.WIDTH(4), .NUM_OPS(2), .OPC_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .nr_coded  (nr_coded),
        .neg_mask  (neg_mask),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .ops_out   (ops_out),
        .operation (operation),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One operand: negation is 16 - op modulo 16; the minimum value flags overflow.
    task automatic neg1(input logic [3:0] op, input logic m, output logic [3:0] v, output logic o);
        int r;
        r = int'(op);
        o = 1'b0;
        if (m) begin
            r = (16 - int'(op)) % 16;
            if (op == 4'd8) begin
                o = 1'b1;
`ifdef TWOS_SAT_EN
                r = 7;
`endif
            end
        end
        v = r[3:0];
    endtask

    task automatic model(input logic [11:0] nr, input logic [1:0] m,
                         output logic [7:0] e_ops, output logic [1:0] e_ovf);
        logic [3:0] v0, v1;
        logic       o0, o1;
        neg1(nr[11:8], m[1], v0, o0);
        neg1(nr[7:4],  m[0], v1, o1);
        e_ops = {v0, v1};
        e_ovf = {o0, o1};
    endtask

    task automatic do_run(input logic [11:0] nr, input logic [1:0] m,
                          input logic [7:0] e_ops, input logic [1:0] e_ovf, input string tag);
        int cyc;
        nr_coded = nr;
        neg_mask = m;
        start    = 1'b1;
        step();
        start    = 1'b0;
        nr_coded = 12'($urandom);
        neg_mask = 2'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        step();
        check({tag, "_hold_ops"}, 32'(ops_out), 32'(prev_ops));
        check({tag, "_hold_ovf"}, 32'(ovf), 32'(prev_ovf));
        cyc = 1;
        while (!done && cyc < 10) begin
            step();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd3);
        check({tag, "_ops"}, 32'(ops_out), 32'(e_ops));
        check({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
        check({tag, "_opc"}, 32'(operation), 32'(nr[3:0]));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        prev_ops = e_ops;
        prev_ovf = e_ovf;
        prev_opc = nr[3:0];
        step();
        check({tag, "_done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [7:0] e_ops;
        logic [1:0] e_ovf;
        int         done_cnt;
        int         first_at;
        int         second_at;

        tbl[0] = '{12'h35A, 2'b11, 8'hDB, 2'b00};
        tbl[2] = '{12'h0F3, 2'b11, 8'h01, 2'b00};
        tbl[3] = '{12'h8C5, 2'b01, 8'h84, 2'b00};
        tbl[6] = '{12'h000, 2'b11, 8'h00, 2'b00};
        tbl[7] = '{12'h8C2, 2'b00, 8'h8C, 2'b00};
`ifdef TWOS_SAT_EN
        tbl[1] = '{12'h801, 2'b10, 8'h70, 2'b10};
        tbl[4] = '{12'h87F, 2'b11, 8'h79, 2'b10};
        tbl[5] = '{12'h88E, 2'b11, 8'h77, 2'b11};
`else
        tbl[1] = '{12'h801, 2'b10, 8'h80, 2'b10};
        tbl[4] = '{12'h87F, 2'b11, 8'h89, 2'b10};
        tbl[5] = '{12'h88E, 2'b11, 8'h88, 2'b11};
`endif

        rst      = 1'b1;
        start    = 1'b0;
        nr_coded = '0;
        neg_mask = '0;
        step();
        step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ops", 32'(ops_out), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_opc", 32'(operation), 32'd0);
        rst = 1'b0;
        prev_ops = '0;
        prev_ovf = '0;
        prev_opc = '0;
        step();

        for (int i = 0; i < 8; i++) begin
            do_run(tbl[i].nr, tbl[i].m, tbl[i].e_ops, tbl[i].e_ovf, $sformatf("vec%0d", i));
        end

        // Input word replaced with all-ones right after capture.
        nr_coded = 12'h35A;
        neg_mask = 2'b11;
        start    = 1'b1;
        step();
        start    = 1'b0;
        nr_coded = 12'hFFF;
        neg_mask = 2'b00;
        done_cnt = 0;
        for (int c = 1; c < 10 && done_cnt == 0; c++) begin
            step();
            if (done) done_cnt++;
        end
        check("late_change_done", 32'(done_cnt), 32'd1);
        check("late_change_ops", 32'(ops_out), 32'hDB);
        check("late_change_opc", 32'(operation), 32'hA);
        prev_ops = 8'hDB;
        prev_ovf = 2'b00;
        step();

        // Start held for six edges: first run completes, one done-cycle blocks a
        // restart, then the still-high start launches a second run at edge 5.
        nr_coded = 12'h0F3;
        neg_mask = 2'b11;
        start    = 1'b1;
        done_cnt = 0;
        first_at = -1;
        second_at = -1;
        for (int c = 0; c < 14; c++) begin
            step();
            if (c == 5) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (first_at < 0) first_at = c;
                else if (second_at < 0) second_at = c;
            end
        end
        check("hold_done_count", 32'(done_cnt), 32'd2);
        check("hold_first_done", 32'(first_at), 32'd3);
        check("hold_second_done", 32'(second_at), 32'd8);
        check("hold_ops", 32'(ops_out), 32'h01);
        prev_ops = 8'h01;
        prev_ovf = 2'b00;

        // Extra start pulse landing mid-conversion is dropped.
        nr_coded = 12'h35A;
        neg_mask = 2'b11;
        start    = 1'b1;
        step();
        start    = 1'b0;
        step();
        start    = 1'b1;
        step();
        start    = 1'b0;
        done_cnt = 0;
        first_at = -1;
        for (int c = 3; c < 13; c++) begin
            if (done) begin
                done_cnt++;
                if (first_at < 0) first_at = c - 1;
            end
            step();
        end
        check("midpulse_done_count", 32'(done_cnt), 32'd1);
        check("midpulse_done_at", 32'(first_at), 32'd3);
        prev_ops = 8'hDB;
        prev_ovf = 2'b00;

        // Reset during the first conversion cycle aborts without a done strobe.
        nr_coded = 12'h801;
        neg_mask = 2'b10;
        start    = 1'b1;
        step();
        start    = 1'b0;
        rst      = 1'b1;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ops", 32'(ops_out), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_opc", 32'(operation), 32'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        prev_ops = '0;
        prev_ovf = '0;

        for (int r = 0; r < 30; r++) begin
            logic [11:0] nr;
            logic [1:0]  m;
            nr = 12'($urandom);
            m  = 2'($urandom);
            if (r % 5 == 0) nr[11:8] = 4'h8;
            model(nr, m, e_ops, e_ovf);
            do_run(nr, m, e_ops, e_ovf, $sformatf("rnd%0d", r));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
